// File: rtl/dct_pkg.sv
// Shared DCT/IDCT definitions: fixed-point constants, datapath types and IDCT state encoding.
package dct_pkg;
  localparam int IDCT_LUT_FRAC = 10;
  localparam int IDCT_ROUND    = 1 << 19;
  localparam int PIX_OFFSET    = 128;

  typedef logic signed [15:0] coeff_t;
  typedef logic signed [11:0] cos_t;
  typedef logic signed [47:0] acc_t;

  typedef enum logic [1:0] {LOAD, MAC, DRAIN, EMIT} idct_state_e;
endpackage

// File: rtl/idct_cos_1d_lut.sv
// 1D IDCT cosine basis C(k,n) = S(k)*cos((2n+1)k*pi/16) in Q10.
module idct_cos_1d_lut
  import dct_pkg::*;
(
  input  logic [2:0] k,
  input  logic [2:0] n,
  output cos_t       c
);
  logic [6:0] angle;
  logic [4:0] m;
  logic [4:0] r;
  logic [4:0] idx;
  logic       neg;
  logic [9:0] mag;

  always_comb begin
    // Angle in units of pi/16, folded onto [0, pi] since cos is even and 2*pi periodic.
    angle = {3'b000, n, 1'b1} * {4'b0000, k};
    m     = angle[4:0];
    r     = (m > 5'd16) ? 5'd0 - m : m;
    neg   = (r > 5'd8);
    idx   = neg ? 5'd16 - r : r;
    case (idx[3:0])
      4'd0:    mag = 10'd512;
      4'd1:    mag = 10'd502;
      4'd2:    mag = 10'd473;
      4'd3:    mag = 10'd426;
      4'd4:    mag = 10'd362;
      4'd5:    mag = 10'd284;
      4'd6:    mag = 10'd196;
      4'd7:    mag = 10'd100;
      default: mag = 10'd0;
    endcase
    if (k == 3'd0) c = 12'sd362;
    else if (neg)  c = -$signed({2'b00, mag});
    else           c = $signed({2'b00, mag});
  end
endmodule

// File: rtl/idct_8x8_engine.sv
// Direct-summation 8x8 IDCT: buffers 64 coefficients, then one MAC per cycle per pixel.
module idct_8x8_engine
  import dct_pkg::*;
#(
  parameter int COEFF_W  = 16,
  parameter int LUT_FRAC = IDCT_LUT_FRAC,
  parameter int ACC_W    = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COEFF_W-1:0] coeff_in,
  input  logic               coeff_valid,
  output logic               coeff_ready,
  output logic [7:0]         pix_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               busy,
  output idct_state_e        dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and the payload stay stable until that edge.
  idct_state_e state;
  logic [5:0] cnt;
  logic [5:0] p;
  logic [5:0] t;
  logic       drain_cnt;
  logic       prod_valid;
  logic signed [COEFF_W-1:0] coeff_buf [64];
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [23:0]        cos2;
  logic [7:0] pix_next;
  cos_t c_row;
  cos_t c_col;

  assign dbg_state = state;

  idct_cos_1d_lut u_lut_row (.k(t[5:3]), .n(p[5:3]), .c(c_row));
  idct_cos_1d_lut u_lut_col (.k(t[2:0]), .n(p[2:0]), .c(c_col));

  assign cos2 = c_row * c_col;
  assign term = ACC_W'(coeff_buf[t]) * ACC_W'(cos2);

  always_comb begin
    rounded = (acc + ACC_W'(IDCT_ROUND)) >>> (2 * LUT_FRAC);
    if (rounded < ACC_W'(-PIX_OFFSET))           pix_next = 8'd0;
    else if (rounded > ACC_W'(255 - PIX_OFFSET)) pix_next = 8'd255;
    else                                         pix_next = rounded[7:0] + 8'(PIX_OFFSET);
  end

  // The coefficient store carries no reset; its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (state == LOAD && coeff_valid && coeff_ready) coeff_buf[cnt] <= coeff_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      p           <= '0;
      t           <= '0;
      drain_cnt   <= 1'b0;
      prod_valid  <= 1'b0;
      prod        <= '0;
      acc         <= '0;
      coeff_ready <= 1'b1;
      pix_valid   <= 1'b0;
      pix_last    <= 1'b0;
      pix_out     <= '0;
      busy        <= 1'b0;
    end else begin
      prod_valid <= 1'b0;
      if (prod_valid) acc <= acc + prod;
      case (state)
        LOAD: begin
          if (coeff_valid && coeff_ready) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state       <= MAC;
              p           <= '0;
              t           <= '0;
              coeff_ready <= 1'b0;
              busy        <= 1'b1;
            end
          end
        end
        MAC: begin
          prod       <= term;
          prod_valid <= 1'b1;
          if (t == 6'd0) acc <= '0;
          t <= t + 6'd1;
          if (t == 6'd63) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            pix_out   <= pix_next;
            pix_valid <= 1'b1;
            pix_last  <= (p == 6'd63);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (p == 6'd63) begin
              state       <= LOAD;
              cnt         <= '0;
              coeff_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              p     <= p + 6'd1;
              t     <= '0;
              state <= MAC;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule
